// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard control unit: register indices and
// enables in, stall/flush/forward controls and the stall counter out.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) ();
  logic [REG_AW-1:0] rs1_D, rs2_D;
  logic [REG_AW-1:0] rs1_E, rs2_E, rd_E;
  logic [REG_AW-1:0] rd_M, rd_W;
  logic              regwrite_M, regwrite_W;
  logic              MemtoregE;
  logic              md_start_E;
  logic              PCSrc_E;

  logic              StallF, StallD, StallE;
  logic              FlushD, FlushE;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              md_busy;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
           regwrite_M, regwrite_W, MemtoregE, md_start_E, PCSrc_E,
    input  StallF, StallD, StallE, FlushD, FlushE,
           ForwardAE, ForwardBE, md_busy, stall_cnt
  );

  modport slave (
    input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
           regwrite_M, regwrite_W, MemtoregE, md_start_E, PCSrc_E,
    output StallF, StallD, StallE, FlushD, FlushE,
           ForwardAE, ForwardBE, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Five-stage pipeline hazard control: operand forwarding, load-use and
// multi-cycle mul/div stalls, branch flushes and a saturating stall counter.
module hazard_ctrl_unit #(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave bus
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  localparam logic [7:0]       MD_LOAD  = 8'(MD_LAT - 1);
  localparam bit               MD_MULTI = (MD_LAT >= 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state;
  logic [7:0]       md_cnt;
  logic [CNT_W-1:0] stall_cnt;

  logic md_entry, md_hold, load_use, branch;
  logic stall_fd, stall_e, flush_d, flush_e;

  // Memory-stage result is younger than Writeback, so it wins a tie.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] rd_m,
    input logic [REG_AW-1:0] rd_w,
    input logic              rw_m,
    input logic              rw_w
  );
    if (rw_m && (rd_m != '0) && (src == rd_m))      return 2'b10;
    else if (rw_w && (rd_w != '0) && (src == rd_w)) return 2'b01;
    else                                            return 2'b00;
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    md_entry = 1'b0;
    md_hold  = 1'b0;
    load_use = 1'b0;
    branch   = 1'b0;
    if (state == RUN) begin
      if (bus.PCSrc_E) begin
        branch = 1'b1;
      end else if (bus.md_start_E && MD_MULTI) begin
        md_entry = 1'b1;
      end else if (bus.MemtoregE && (bus.rd_E != '0) &&
                   ((bus.rd_E == bus.rs1_D) || (bus.rd_E == bus.rs2_D))) begin
        load_use = 1'b1;
      end
    end else begin
      // The final MD_WAIT cycle lets the pipeline move again.
      md_hold = (md_cnt > 8'd1);
    end
  end

  // All controls are held inactive while reset is asserted.
  assign stall_fd = rst_n & (md_entry | md_hold | load_use);
  assign stall_e  = rst_n & (md_entry | md_hold);
  assign flush_d  = rst_n & branch;
  assign flush_e  = rst_n & (branch | load_use);

  assign bus.StallF    = stall_fd;
  assign bus.StallD    = stall_fd;
  assign bus.StallE    = stall_e;
  assign bus.FlushD    = flush_d;
  assign bus.FlushE    = flush_e;
  assign bus.ForwardAE = rst_n ? fwd_sel(bus.rs1_E, bus.rd_M, bus.rd_W,
                                         bus.regwrite_M, bus.regwrite_W) : 2'b00;
  assign bus.ForwardBE = rst_n ? fwd_sel(bus.rs2_E, bus.rd_M, bus.rd_W,
                                         bus.regwrite_M, bus.regwrite_W) : 2'b00;
  assign bus.md_busy   = rst_n & (state == MD_WAIT);
  assign bus.stall_cnt = stall_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous and checked first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      md_cnt    <= 8'd0;
      stall_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (md_entry) begin
            state  <= MD_WAIT;
            md_cnt <= MD_LOAD;
          end
        end
        MD_WAIT: begin
          md_cnt <= md_cnt - 8'd1;
          if (md_cnt <= 8'd1) state <= RUN;
        end
        default: begin
          state  <= RUN;
          md_cnt <= 8'd0;
        end
      endcase
      if (stall_fd && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench: default unit, a 4-bit-counter unit and an MD_LAT=1 unit
// share one stimulus stream; checked by table, hand sequences and a model.
module tb_hazard_ctrl_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) ifa ();
  hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  ifb ();
  hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) ifc ();

  hazard_ctrl_unit #(.REG_AW(5), .MD_LAT(4), .CNT_W(32)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  hazard_ctrl_unit #(.REG_AW(5), .MD_LAT(4), .CNT_W(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
  hazard_ctrl_unit #(.REG_AW(5), .MD_LAT(1), .CNT_W(32)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  assign {ifb.rs1_D, ifb.rs2_D, ifb.rs1_E, ifb.rs2_E, ifb.rd_E, ifb.rd_M, ifb.rd_W,
          ifb.regwrite_M, ifb.regwrite_W, ifb.MemtoregE, ifb.md_start_E, ifb.PCSrc_E} =
         {ifa.rs1_D, ifa.rs2_D, ifa.rs1_E, ifa.rs2_E, ifa.rd_E, ifa.rd_M, ifa.rd_W,
          ifa.regwrite_M, ifa.regwrite_W, ifa.MemtoregE, ifa.md_start_E, ifa.PCSrc_E};
  assign {ifc.rs1_D, ifc.rs2_D, ifc.rs1_E, ifc.rs2_E, ifc.rd_E, ifc.rd_M, ifc.rd_W,
          ifc.regwrite_M, ifc.regwrite_W, ifc.MemtoregE, ifc.md_start_E, ifc.PCSrc_E} =
         {ifa.rs1_D, ifa.rs2_D, ifa.rs1_E, ifa.rs2_E, ifa.rd_E, ifa.rd_M, ifa.rd_W,
          ifa.regwrite_M, ifa.regwrite_W, ifa.MemtoregE, ifa.md_start_E, ifa.PCSrc_E};

  typedef struct packed {
    logic       rst_n;
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic       rw_M, rw_W, mem_E, md_E, pc_E;
  } in_t;

  typedef struct packed {
    logic       sf, sd, se, fd, fe, busy;
    logic [1:0] fa, fb;
  } exp_t;

  typedef struct {
    string name;
    in_t   in;
    exp_t  ex;
  } vec_t;

  exp_t out_a, out_b, out_c;
  assign out_a = {ifa.StallF, ifa.StallD, ifa.StallE, ifa.FlushD, ifa.FlushE, ifa.md_busy, ifa.ForwardAE, ifa.ForwardBE};
  assign out_b = {ifb.StallF, ifb.StallD, ifb.StallE, ifb.FlushD, ifb.FlushE, ifb.md_busy, ifb.ForwardAE, ifb.ForwardBE};
  assign out_c = {ifc.StallF, ifc.StallD, ifc.StallE, ifc.FlushD, ifc.FlushE, ifc.md_busy, ifc.ForwardAE, ifc.ForwardBE};

  int checks = 0;
  int errors = 0;

  // Reference state: cycles the mul/div op still has left in Execute, and stall totals.
  int     occ_a = 0, occ_c = 0;
  longint cnt_a = 0, cnt_c = 0;

  exp_t        last_a, last_b, last_c;
  logic [31:0] last_cnt_a, last_cnt_c;
  logic [3:0]  last_cnt_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input in_t v, input logic [4:0] src);
    if (v.rw_M && v.rd_M != 0 && src == v.rd_M) return 2'b10;
    if (v.rw_W && v.rd_W != 0 && src == v.rd_W) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t ref_model(input int md_lat, input int occ, input in_t v);
    exp_t e = '0;
    if (!v.rst_n) return e;
    e.fa = ref_fwd(v, v.rs1_E);
    e.fb = ref_fwd(v, v.rs2_E);
    if (occ > 0) begin
      e.busy = 1'b1;
      if (occ > 1) {e.sf, e.sd, e.se} = 3'b111;
    end else if (v.pc_E) begin
      {e.fd, e.fe} = 2'b11;
    end else if (v.md_E && md_lat > 1) begin
      {e.sf, e.sd, e.se} = 3'b111;
    end else if (v.mem_E && v.rd_E != 0 && (v.rd_E == v.rs1_D || v.rd_E == v.rs2_D)) begin
      {e.sf, e.sd, e.fe} = 3'b111;
    end
    return e;
  endfunction

  function automatic int ref_occ_next(input int md_lat, input int occ, input in_t v);
    if (!v.rst_n) return 0;
    if (occ > 0) return occ - 1;
    if (v.md_E && !v.pc_E && md_lat > 1) return md_lat - 1;
    return 0;
  endfunction

  function automatic in_t idle();
    in_t v = '0;
    v.rst_n = 1'b1;
    return v;
  endfunction

  task automatic drive(input in_t v);
    rst_n          = v.rst_n;
    ifa.rs1_D      = v.rs1_D;  ifa.rs2_D = v.rs2_D;
    ifa.rs1_E      = v.rs1_E;  ifa.rs2_E = v.rs2_E;  ifa.rd_E = v.rd_E;
    ifa.rd_M       = v.rd_M;   ifa.rd_W  = v.rd_W;
    ifa.regwrite_M = v.rw_M;   ifa.regwrite_W = v.rw_W;
    ifa.MemtoregE  = v.mem_E;  ifa.md_start_E = v.md_E;  ifa.PCSrc_E = v.pc_E;
  endtask

  // One clock cycle: drive, sample on the falling edge, compare to the model, advance.
  task automatic step(input in_t v);
    exp_t ea, ec;
    drive(v);
    @(negedge clk);
    last_a = out_a; last_b = out_b; last_c = out_c;
    last_cnt_a = ifa.stall_cnt; last_cnt_b = ifb.stall_cnt; last_cnt_c = ifc.stall_cnt;
    ea = ref_model(4, occ_a, v);
    ec = ref_model(1, occ_c, v);
    check("model_out_a", 64'(last_a), 64'(ea));
    check("model_out_b", 64'(last_b), 64'(ea));
    check("model_out_c", 64'(last_c), 64'(ec));
    check("model_cnt_a", 64'(last_cnt_a), 64'(cnt_a));
    check("model_cnt_b", 64'(last_cnt_b), 64'((cnt_a > 15) ? 15 : cnt_a));
    check("model_cnt_c", 64'(last_cnt_c), 64'(cnt_c));
    @(posedge clk);
    if (!v.rst_n) begin
      cnt_a = 0; cnt_c = 0;
    end else begin
      cnt_a += longint'(ea.sf);
      cnt_c += longint'(ec.sf);
    end
    occ_a = ref_occ_next(4, occ_a, v);
    occ_c = ref_occ_next(1, occ_c, v);
    #1;
  endtask

  vec_t   tbl[$];
  in_t    v;
  logic   exp_stall[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic   exp_busy[4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
  longint c0;

  initial begin
    v = idle();
    v.rst_n = 1'b0;
    drive(v);
    @(posedge clk);
    #1;
    step(v);
    check("reset_outputs", 64'(last_a), 64'(0));

    v = idle();
    step(v);
    check("post_reset_cnt", 64'(last_cnt_a), 64'(0));
    check("post_reset_busy", 64'(last_a.busy), 64'(0));

    // Single-cycle vectors, each applied from an idle RUN state.
    v = idle(); v.rw_M = 1; v.rd_M = 5; v.rw_W = 1; v.rd_W = 5; v.rs1_E = 5;
    tbl.push_back('{"fwd_mem_prio", v, exp_t'({6'b0, 2'b10, 2'b00})});
    v.rd_M = 0;
    tbl.push_back('{"fwd_wb", v, exp_t'({6'b0, 2'b01, 2'b00})});
    v.rs1_E = 0; v.rd_W = 0;
    tbl.push_back('{"fwd_none", v, exp_t'({6'b0, 2'b00, 2'b00})});
    v = idle(); v.rw_M = 1; v.rd_M = 9; v.rs2_E = 9; v.rs1_E = 3; v.rd_W = 3;
    tbl.push_back('{"fwd_b_mem_wb_off", v, exp_t'({6'b0, 2'b00, 2'b10})});
    v = idle(); v.mem_E = 1; v.rd_E = 7; v.rs2_D = 7;
    tbl.push_back('{"load_use_rs2", v, exp_t'({6'b110010, 2'b00, 2'b00})});
    v.rd_E = 0; v.rs2_D = 0;
    tbl.push_back('{"load_use_rd0", v, exp_t'({6'b0, 2'b00, 2'b00})});
    v = idle(); v.mem_E = 0; v.rd_E = 4; v.rs1_D = 4;
    tbl.push_back('{"no_load_no_stall", v, exp_t'({6'b0, 2'b00, 2'b00})});
    v = idle(); v.pc_E = 1; v.mem_E = 1; v.rd_E = 3; v.rs1_D = 3;
    tbl.push_back('{"branch_over_load", v, exp_t'({6'b000110, 2'b00, 2'b00})});
    v = idle(); v.pc_E = 1; v.md_E = 1;
    tbl.push_back('{"branch_blocks_md", v, exp_t'({6'b000110, 2'b00, 2'b00})});
    tbl.push_back('{"after_branch_run", idle(), exp_t'({6'b0, 2'b00, 2'b00})});

    foreach (tbl[i]) begin
      step(tbl[i].in);
      check(tbl[i].name, 64'(last_a), 64'(tbl[i].ex));
    end

    // Load-use adds exactly one stall cycle to the counter.
    c0 = longint'(last_cnt_a);
    v = idle(); v.mem_E = 1; v.rd_E = 7; v.rs2_D = 7;
    step(v);
    step(idle());
    check("load_use_cnt_plus1", 64'(last_cnt_a), 64'(c0 + 1));
    check("load_use_one_cycle", 64'(last_a.sf), 64'(0));

    // Mul/div held for four cycles: three stall cycles, busy in the last three.
    c0 = longint'(last_cnt_a);
    for (int i = 0; i < 4; i++) begin
      v = idle(); v.md_E = 1;
      step(v);
      check($sformatf("md_stall_t%0d", i), 64'({last_a.sf, last_a.sd, last_a.se, last_a.fe}),
            64'({exp_stall[i], exp_stall[i], exp_stall[i], 1'b0}));
      check($sformatf("md_busy_t%0d", i), 64'(last_a.busy), 64'(exp_busy[i]));
      check($sformatf("md_lat1_nostall_t%0d", i), 64'({last_c.sf, last_c.busy}), 64'(0));
    end
    step(idle());
    check("md_cnt_plus3", 64'(last_cnt_a), 64'(c0 + 3));
    check("md_done_busy", 64'(last_a.busy), 64'(0));

    // Reset asserted while two MD_WAIT cycles remain.
    v = idle(); v.md_E = 1;
    step(v);
    step(idle());
    check("md_mid_busy", 64'(last_a.busy), 64'(1));
    v = idle(); v.rst_n = 0; v.mem_E = 1; v.rd_E = 2; v.rs1_D = 2; v.rw_M = 1; v.rd_M = 1; v.rs1_E = 1;
    step(v);
    check("rst_forced_zero", 64'(last_a), 64'(0));
    step(idle());
    check("rst_mid_outputs", 64'(last_a), 64'(0));
    check("rst_mid_cnt", 64'(last_cnt_a), 64'(0));

    // Twenty load-use cycles: the 4-bit counter pins at 15.
    v = idle(); v.mem_E = 1; v.rd_E = 6; v.rs1_D = 6;
    for (int i = 0; i < 20; i++) step(v);
    step(idle());
    check("sat_cnt_b", 64'(last_cnt_b), 64'(15));
    check("sat_cnt_a", 64'(last_cnt_a), 64'(20));
    step(idle());
    check("sat_cnt_b_hold", 64'(last_cnt_b), 64'(15));

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      v.rst_n = ($urandom_range(0, 49) != 0);
      v.rs1_D = 5'($urandom_range(0, 5)); v.rs2_D = 5'($urandom_range(0, 5));
      v.rs1_E = 5'($urandom_range(0, 5)); v.rs2_E = 5'($urandom_range(0, 5));
      v.rd_E  = 5'($urandom_range(0, 5)); v.rd_M  = 5'($urandom_range(0, 5));
      v.rd_W  = 5'($urandom_range(0, 5));
      v.rw_M  = 1'($urandom_range(0, 1)); v.rw_W  = 1'($urandom_range(0, 1));
      v.mem_E = 1'($urandom_range(0, 1));
      v.md_E  = ($urandom_range(0, 5) == 0);
      v.pc_E  = ($urandom_range(0, 6) == 0);
      step(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 Parameter REG_AW, default 5, register-index width.
REQ-002 Parameter MD_LAT, default 4, number of cycles a mul/div instruction occupies Execute; legal range 1..255.
REQ-003 Parameter CNT_W, default 32, width of the stall performance counter.
REQ-004 clk  input  1  the single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 rs1_D, rs2_D  input  REG_AW  source registers in Decode.
REQ-007 rs1_E, rs2_E, rd_E  input  REG_AW  sources and destination in Execute.
REQ-008 rd_M, rd_W  input  REG_AW  destinations in Memory and Writeback.
REQ-009 regwrite_M, regwrite_W  input  1  register write enables of Memory and Writeback.
REQ-010 MemtoregE  input  1  Execute instruction is a load.
REQ-011 md_start_E  input  1  Execute instruction is mul/div.
REQ-012 PCSrc_E  input  1  taken branch or jump resolved in Execute.
REQ-013 StallF, StallD, StallE  output  1  hold PC, IF/ID, and ID/EX registers.
REQ-014 FlushD, FlushE  output  1  clear IF/ID and ID/EX to bubble.
REQ-015 ForwardAE, ForwardBE  output  2  ALU operand mux selects: 00 register file, 10 Memory result, 01 Writeback result.
REQ-016 md_busy  output  1  FSM is in MD_WAIT.
REQ-017 stall_cnt  output  CNT_W  count of cycles with StallF high.

Function
REQ-018 Forwarding is combinational for operand A.
- ForwardAE=10 if regwrite_M, rd_M!=0 and rs1_E==rd_M.
- Else ForwardAE=01 if regwrite_W, rd_W!=0 and rs1_E==rd_W.
- Else ForwardAE=00.
- Memory match always takes priority over Writeback match.
REQ-019 ForwardBE follows the REQ-018 rules with rs2_E in place of rs1_E.
REQ-020 The FSM has two states, RUN and MD_WAIT, and uses an 8-bit down-counter md_cnt.
REQ-021 RUN transitions:
- If md_start_E is 1, PCSrc_E is 0 and MD_LAT>=2, the next state is MD_WAIT and md_cnt is loaded with MD_LAT-1.
- Otherwise the FSM stays in RUN.
REQ-022 MD_WAIT transitions:
- md_cnt decrements each cycle.
- When md_cnt==1, the next state is RUN.
- md_start_E, MemtoregE and PCSrc_E are ignored while in MD_WAIT.
REQ-023 Mul/div stall (combinational), asserted in either case below:
- In RUN, when the REQ-021 entry condition holds.
- In MD_WAIT, when md_cnt>1.
- In both cases StallF=StallD=StallE=1 and FlushE=0.
- Result: exactly MD_LAT-1 stall cycles and MD_LAT cycles of Execute occupancy.
REQ-024 Load-use stall: in RUN, when there is no branch and no mul/div entry, and MemtoregE=1, rd_E!=0, and rd_E equals rs1_D or rs2_D:
- StallF=StallD=1, FlushE=1, StallE=0, for that cycle only.
REQ-025 Branch flush: in RUN, when PCSrc_E=1:
- FlushD=FlushE=1, and all stalls are 0.
- This overrides the load-use stall and blocks mul/div entry.
REQ-026 Priority in RUN is PCSrc_E, then mul/div entry, then load-use.
REQ-027 With MD_LAT=1, md_start_E has no effect and the FSM never leaves RUN.
REQ-028 stall_cnt increments by 1 on every clock edge where StallF=1 and saturates at all ones (no wrap).
REQ-029 md_busy is 1 exactly when the state is MD_WAIT.
REQ-030 Forwarding outputs stay active in every state.

Reset
REQ-031 On a rising edge with rst_n=0:
- The state becomes RUN, md_cnt becomes 0 and stall_cnt becomes 0.
- This takes priority over every other update, including mid-MD_WAIT.
REQ-032 While rst_n=0:
- StallF, StallD, StallE, FlushD and FlushE are forced to 0.
- ForwardAE and ForwardBE are forced to 00.
- md_busy is 0.
REQ-033 After rst_n rises, the first cycle behaves as RUN with counters at zero.

Verification
REQ-034 Forward priority: regwrite_M=1, rd_M=5, regwrite_W=1, rd_W=5, rs1_E=5 -> ForwardAE=10. With rd_M=0 -> ForwardAE=01. With rs1_E=0 and rd_M=rd_W=0 -> ForwardAE=00.
REQ-035 Load-use: MemtoregE=1, rd_E=7, rs2_D=7 -> StallF=StallD=FlushE=1 for one cycle and stall_cnt +1. With rd_E=0 -> all 0.
REQ-036 Mul/div with MD_LAT=4: md_start_E held 4 cycles from cycle t:
- Stalls high in cycles t, t+1, t+2 and low at t+3.
- md_busy high in t+1..t+3.
- stall_cnt +3.
REQ-037 Branch vs hazard: PCSrc_E=1, MemtoregE=1, rd_E=3, rs1_D=3 -> FlushD=FlushE=1 and StallF=StallD=0. PCSrc_E=1 with md_start_E=1 -> FSM stays RUN.
REQ-038 Reset mid-operation: rst_n=0 during MD_WAIT with md_cnt=2 -> next cycle state RUN, md_busy=0, stall_cnt=0, all stalls/flushes 0.
REQ-039 Saturation: with CNT_W=4, hold load-use stall for 20 cycles -> stall_cnt reaches 15 and stays at 15.
